// File: rtl/seg_display_driver.sv
// Six-position multiplexed 7-segment driver (sign + five BCD digits) with
// frame-synchronous double buffering. Optional: LEADING_ZERO_BLANK_EN.
module seg_display_driver #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       sign,
    input  logic [3:0] d4,
    input  logic [3:0] d3,
    input  logic [3:0] d2,
    input  logic [3:0] d1,
    input  logic [3:0] d0,
    input  logic [2:0] dp_pos,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_done
);

    localparam int unsigned CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [2:0] IDX_SIGN = 3'd5;

    typedef struct packed {
        logic       sign;
        logic [3:0] d4;
        logic [3:0] d3;
        logic [3:0] d2;
        logic [3:0] d1;
        logic [3:0] d0;
        logic [2:0] dp_pos;
    } frame_t;

    logic [CW-1:0] div_cnt;
    logic [2:0]    idx;
    logic [2:0]    next_idx;
    logic          tick;
    logic          boundary;
    logic          pending;
    frame_t        shadow;
    frame_t        active;
    frame_t        next_active;
    logic [3:0]    dig [8];
    logic [7:0]    lz;
    logic [5:0]    an_d;
    logic [6:0]    seg_d;
    logic          dp_d;

    function automatic logic [6:0] seg_code(input logic [3:0] v);
        case (v)
            4'd0:    seg_code = 7'b1000000;
            4'd1:    seg_code = 7'b1111001;
            4'd2:    seg_code = 7'b0100100;
            4'd3:    seg_code = 7'b0110000;
            4'd4:    seg_code = 7'b0011001;
            4'd5:    seg_code = 7'b0010010;
            4'd6:    seg_code = 7'b0000010;
            4'd7:    seg_code = 7'b1111000;
            4'd8:    seg_code = 7'b0000000;
            4'd9:    seg_code = 7'b0010000;
            default: seg_code = 7'b0111111;
        endcase
    endfunction

    assign tick        = (div_cnt == CW'(REFRESH_DIV - 1));
    assign boundary    = tick && (idx == IDX_SIGN);
    assign next_idx    = (idx == IDX_SIGN) ? 3'd0 : idx + 3'd1;
    assign next_active = (boundary && pending) ? shadow : active;

    // Decode from the post-edge index and frame so the registered outputs
    // switch on the same edge as the index and never mix two frames.
    always_comb begin
        dig[0] = next_active.d0;
        dig[1] = next_active.d1;
        dig[2] = next_active.d2;
        dig[3] = next_active.d3;
        dig[4] = next_active.d4;
        dig[5] = '0;
        dig[6] = '0;
        dig[7] = '0;
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Blank a zero only while every digit to its left is a blanked zero;
    // the decimal-point digit and d0 always show.
    always_comb begin
        logic run;
        lz  = '0;
        run = 1'b1;
        for (int unsigned k = 4; k >= 1; k--) begin
            run   = run && (dig[k] == 4'd0) && (next_active.dp_pos != 3'(k));
            lz[k] = run;
        end
    end
`else
    assign lz = '0;
`endif

    always_comb begin
        an_d          = '1;
        an_d[next_idx] = 1'b0;
        dp_d          = 1'b1;
        if (next_idx == IDX_SIGN) begin
            seg_d = next_active.sign ? 7'b0111111 : 7'b1111111;
        end else begin
            seg_d = lz[next_idx] ? 7'b1111111 : seg_code(dig[next_idx]);
            dp_d  = (next_active.dp_pos != next_idx);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt    <= '0;
            idx        <= IDX_SIGN;
            an         <= '1;
            seg        <= '1;
            dp         <= 1'b1;
            frame_done <= 1'b0;
            shadow     <= '0;
            active     <= '0;
            pending    <= 1'b0;
        end else begin
            div_cnt    <= tick ? '0 : div_cnt + CW'(1);
            frame_done <= boundary;
            if (tick) begin
                idx <= next_idx;
                an  <= an_d;
                seg <= seg_d;
                dp  <= dp_d;
            end
            active <= next_active;
            if (load) begin
                shadow  <= '{sign, d4, d3, d2, d1, d0, dp_pos};
                pending <= 1'b1;
            end else if (boundary) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_display_driver.sv
// Bench for seg_display_driver (REFRESH_DIV=4): table of frames checked through
// an expected-output queue, plus hand sequences for boundary loads and resets.
module tb_seg_display_driver;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                           S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                           S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                           S9 = 7'b0010000, SD = 7'b0111111, SB = 7'b1111111;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] ZB = SB;
`else
    localparam logic [6:0] ZB = S0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       load = 1'b0;
    logic       sign = 1'b0;
    logic [3:0] d4 = '0, d3 = '0, d2 = '0, d1 = '0, d0 = '0;
    logic [2:0] dp_pos = '0;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_done;

    seg_display_driver #(.REFRESH_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .sign(sign),
        .d4(d4), .d3(d3), .d2(d2), .d1(d1), .d0(d0), .dp_pos(dp_pos),
        .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sign;
        logic [19:0] d;
        logic [2:0]  dp_pos;
        int          lpos;
        bit          junk;
        logic [6:0]  seg [6];
        logic [5:0]  dpn;
    } vec_t;

    typedef struct packed {
        logic [5:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    localparam int NV = 8;
    vec_t tbl [NV];
    exp_t q [$];
    int   n_chk = 0;
    int   n_fail = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    function automatic void set_vec(input int i, input logic s, input logic [19:0] d,
                                    input logic [2:0] dpp, input int lpos, input bit junk,
                                    input logic [6:0] p0, input logic [6:0] p1, input logic [6:0] p2,
                                    input logic [6:0] p3, input logic [6:0] p4, input logic [6:0] p5,
                                    input logic [5:0] dpn);
        tbl[i].sign = s;   tbl[i].d = d;   tbl[i].dp_pos = dpp;
        tbl[i].lpos = lpos; tbl[i].junk = junk; tbl[i].dpn = dpn;
        tbl[i].seg[0] = p0; tbl[i].seg[1] = p1; tbl[i].seg[2] = p2;
        tbl[i].seg[3] = p3; tbl[i].seg[4] = p4; tbl[i].seg[5] = p5;
    endfunction

    function automatic void push_exp(input int i);
        exp_t e;
        for (int p = 0; p < 6; p++) begin
            e.an     = 6'b111111;
            e.an[p]  = 1'b0;
            e.seg    = tbl[i].seg[p];
            e.dp     = tbl[i].dpn[p];
            q.push_back(e);
        end
    endfunction

    // Drive a one-cycle load at the current negedge, then scramble the inputs.
    task automatic drive(input logic s, input logic [19:0] d, input logic [2:0] dpp);
        sign = s;
        {d4, d3, d2, d1, d0} = d;
        dp_pos = dpp;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        sign = 1'($urandom);
        {d4, d3, d2, d1, d0} = 20'($urandom);
        dp_pos = 3'($urandom);
    endtask

    task automatic drive_idx(input int i);
        drive(tbl[i].sign, tbl[i].d, tbl[i].dp_pos);
    endtask

    task automatic wait_frame();
        int k = 0;
        while (!frame_done && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("frame_done_wait", 32'(frame_done), 32'd1);
    endtask

    task automatic check_frame(input int ld_pos, input int ld_idx, input bit junk);
        exp_t e;
        int   n;
        wait_frame();
        for (int p = 0; p < 6; p++) begin
            if (q.size() == 0) begin
                chk($sformatf("queue_empty_p%0d", p), 32'(q.size()), 32'd1);
            end else begin
                e = q.pop_front();
                chk($sformatf("an_p%0d", p), 32'(an), 32'(e.an));
                chk($sformatf("seg_p%0d", p), 32'(seg), 32'(e.seg));
                chk($sformatf("dp_p%0d", p), 32'(dp), 32'(e.dp));
            end
            n = 0;
            if (p == ld_pos) begin
                if (junk) begin
                    drive(1'b1, 20'h88888, 3'd0);
                    n++;
                end
                push_exp(ld_idx);
                drive_idx(ld_idx);
                n++;
            end
            if (p < 5) begin
                repeat (4 - n) begin
                    @(negedge clk);
                    chk("frame_done_low", 32'(frame_done), 32'd0);
                end
            end
        end
    endtask

    // Called at the negedge where rst_n was just released.
    task automatic release_checks();
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("blank_an", 32'(an), 32'h3f);
            chk("blank_seg", 32'(seg), 32'h7f);
            chk("blank_fd", 32'(frame_done), 32'd0);
        end
        @(negedge clk);
        chk("first_tick_fd", 32'(frame_done), 32'd1);
        chk("first_tick_an", 32'(an), 32'b111110);
    endtask

    task automatic reset_value_checks(input string tag);
        chk({tag, "_an"}, 32'(an), 32'h3f);
        chk({tag, "_seg"}, 32'(seg), 32'h7f);
        chk({tag, "_dp"}, 32'(dp), 32'd1);
        chk({tag, "_fd"}, 32'(frame_done), 32'd0);
    endtask

    initial begin
        set_vec(0, 1'b0, 20'h00000, 3'd0, 0, 1'b0, S0, ZB, ZB, ZB, ZB, SB, 6'b111110);
        set_vec(1, 1'b0, 20'h08000, 3'd3, 5, 1'b0, S0, S0, S0, S8, ZB, SB, 6'b110111);
        set_vec(2, 1'b1, 20'h00100, 3'd2, 2, 1'b0, S0, S0, S1, ZB, ZB, SD, 6'b111011);
        set_vec(3, 1'b0, 20'h9765A, 3'd7, 4, 1'b1, SD, S5, S6, S7, S9, SB, 6'b111111);
        set_vec(4, 1'b1, 20'h234B0, 3'd4, 5, 1'b0, S0, SD, S4, S3, S2, SD, 6'b101111);
        set_vec(5, 1'b0, 20'h00000, 3'd1, 5, 1'b0, S0, S0, ZB, ZB, ZB, SB, 6'b111101);
        set_vec(6, 1'b0, 20'h00007, 3'd5, 0, 1'b0, S7, ZB, ZB, ZB, ZB, SB, 6'b111111);
        set_vec(7, 1'b1, 20'h03009, 3'd7, 5, 1'b0, S9, S0, S0, S3, ZB, SD, 6'b111111);

        #1 rst_n = 1'b0;
        #1 reset_value_checks("rst_async");
        repeat (3) @(negedge clk);
        reset_value_checks("rst_hold");
        rst_n = 1'b1;
        release_checks();

        push_exp(0);
        for (int i = 0; i < NV; i++) begin
            if (i + 1 < NV) check_frame(tbl[i + 1].lpos, i + 1, tbl[i + 1].junk);
            else            check_frame(-1, 0, 1'b0);
        end

        // Load coinciding with the boundary while nothing is pending.
        repeat (3) @(negedge clk);
        push_exp(7);
        push_exp(1);
        drive_idx(1);
        check_frame(-1, 0, 1'b0);
        check_frame(-1, 0, 1'b0);

        // Load coinciding with the boundary while a load is pending.
        push_exp(2);
        drive_idx(2);
        repeat (2) @(negedge clk);
        push_exp(3);
        drive_idx(3);
        check_frame(-1, 0, 1'b0);
        check_frame(-1, 0, 1'b0);
        chk("queue_drained", 32'(q.size()), 32'd0);

        // Reset pulse in the middle of a frame.
        wait_frame();
        repeat (12) @(negedge clk);
        chk("mid_idx3_an", 32'(an), 32'b110111);
        #1 rst_n = 1'b0;
        #1 reset_value_checks("rst_mid");
        @(negedge clk);
        @(negedge clk);
        reset_value_checks("rst_mid_hold");
        rst_n = 1'b1;
        q.delete();
        release_checks();
        push_exp(0);
        check_frame(-1, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
